// File: rtl/scoreboard_controller.sv
// -----------------------------------------------------------------------------
// scoreboard_controller
//
// Purpose:
//   Keeps a 6-digit BCD game score. Point, pellet and ghost events are
//   accumulated, with an escalating ghost chain. The score is rendered as
//   pixel-cell flags and sprite codes for a score line and a blinking "1UP"
//   label.
//
// Ports:
//   Clk                    system clock, rising edge
//   Reset_n                asynchronous active-low reset
//   frame_tick             one pulse per video frame
//   clear_score            new-game pulse (wins over same-cycle events)
//   point_eaten            +10
//   pellet_eaten           +50, restarts the ghost chain
//   ghost_eaten            +200/400/800/1600 depending on the chain index
//   DrawX, DrawY           current pixel coordinates
//   score_bcd              live score, digit 5 in bits [23:20]
//   is_scoreboard          pixel is inside a visible score digit cell
//   scoreboard_sprite      digit value 0-9 for that cell
//   is_scoreboard_1up      pixel is inside a visible "1UP" cell
//   scoreboard_1up_sprite  00 = '1', 01 = 'U', 10 = 'P'
//   extra_life             one-cycle pulse when the score first reaches 10000
//
// Optional feature:
//   Define SCORE_EXTRA_LIFE_EN to enable the extra_life pulse and its sticky
//   flag. Without it, extra_life is tied to 0.
// -----------------------------------------------------------------------------
module scoreboard_controller (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_tick,
   input  logic        clear_score,
   input  logic        point_eaten,
   input  logic        pellet_eaten,
   input  logic        ghost_eaten,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [23:0] score_bcd,
   output logic        is_scoreboard,
   output logic [3:0]  scoreboard_sprite,
   output logic        is_scoreboard_1up,
   output logic [1:0]  scoreboard_1up_sprite,
   output logic        extra_life
);

   logic [23:0] score_q;
   logic [23:0] shadow_q;
   logic [1:0]  k_q;
   logic [3:0]  frame_cnt_q;
   logic        blink_q;

   logic [1:0]  k_eff;
   logic [1:0]  k_next;
   logic [23:0] inc_bcd;
   logic [23:0] score_next;

   // A pellet restarts the chain before a same-cycle ghost is scored.
   assign k_eff = pellet_eaten ? 2'd0 : k_q;

   // The increment is built directly as BCD digits: the tens digit never
   // exceeds 6 and the ghost values never share a digit, so no carries occur.
   always_comb begin
      logic [3:0] tens;
      logic [3:0] hund;
      logic [3:0] thou;
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      tens = 4'd0;
      hund = 4'd0;
      thou = 4'd0;
      if (point_eaten)  tens = tens + 4'd1;
      if (pellet_eaten) tens = tens + 4'd5;
      if (ghost_eaten) begin
         case (k_eff)
            2'd0:    hund = 4'd2;
            2'd1:    hund = 4'd4;
            2'd2:    hund = 4'd8;
            default: begin hund = 4'd6; thou = 4'd1; end
         endcase
      end
      inc_bcd = {8'h00, thou, hund, tens, 4'h0};
   end

   // Digit-serial BCD addition; a carry out of digit 5 saturates at 999999.
   always_comb begin
      logic [4:0]  dsum;
      logic        carry;
      logic [23:0] sum;
      carry = 1'b0;
      sum   = 24'h0;
      dsum  = 5'd0;
      for (int i = 0; i < 6; i++) begin
         dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, inc_bcd[4*i +: 4]} + {4'd0, carry};
         if (dsum > 5'd9) begin
            dsum  = dsum + 5'd6;  // wraps the low nibble by -10
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         sum[4*i +: 4] = dsum[3:0];
      end
      score_next = carry ? 24'h999999 : sum;
   end

   always_comb begin
      k_next = k_eff;
      if (ghost_eaten && k_eff != 2'd3) k_next = k_eff + 2'd1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         score_q     <= 24'h0;
         shadow_q    <= 24'h0;
         k_q         <= 2'd0;
         frame_cnt_q <= 4'd0;
         blink_q     <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 4'd1;
            if (frame_cnt_q == 4'hF) blink_q <= ~blink_q;
         end
         if (clear_score) begin
            score_q  <= 24'h0;
            shadow_q <= 24'h0;
            k_q      <= 2'd0;
         end else begin
            score_q <= score_next;
            k_q     <= k_next;
            if (frame_tick) shadow_q <= score_q;
         end
      end
   end

`ifdef SCORE_EXTRA_LIFE_EN
   logic life_flag_q;
   logic life_hit;

   assign life_hit = (score_next[23:16] != 8'h00) && !life_flag_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         life_flag_q <= 1'b0;
         extra_life  <= 1'b0;
      end else if (clear_score) begin
         life_flag_q <= 1'b0;
         extra_life  <= 1'b0;
      end else begin
         extra_life  <= life_hit;
         life_flag_q <= life_flag_q | life_hit;
      end
   end
`else
   assign extra_life = 1'b0;
`endif

   assign score_bcd = score_q;

   // Score line: walk digits from the top so leading zeros can be suppressed.
   always_comb begin
      logic seen_nonzero;
      is_scoreboard     = 1'b0;
      scoreboard_sprite = 4'd0;
      seen_nonzero      = 1'b0;
      if (DrawY >= 10'd18 && DrawY <= 10'd29) begin
         for (int i = 5; i >= 0; i--) begin
            seen_nonzero = seen_nonzero | (shadow_q[4*i +: 4] != 4'd0);
            if (int'(DrawX) >= 72 + 12*(5-i) && int'(DrawX) <= 83 + 12*(5-i) &&
                (seen_nonzero || i <= 1)) begin
               is_scoreboard     = 1'b1;
               scoreboard_sprite = shadow_q[4*i +: 4];
            end
         end
      end
   end

   always_comb begin
      is_scoreboard_1up     = 1'b0;
      scoreboard_1up_sprite = 2'b00;
      if (blink_q && DrawY <= 10'd11 && DrawX >= 10'd108 && DrawX <= 10'd143) begin
         is_scoreboard_1up = 1'b1;
         if (DrawX <= 10'd119)      scoreboard_1up_sprite = 2'b00;
         else if (DrawX <= 10'd131) scoreboard_1up_sprite = 2'b01;
         else                       scoreboard_1up_sprite = 2'b10;
      end
   end

endmodule

// File: tb/tb_scoreboard_controller.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_controller
//
// Purpose:
//   Directed bench for scoreboard_controller with hand-computed expectations.
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge. Honours SCORE_EXTRA_LIFE_EN for the extra_life expectation.
// -----------------------------------------------------------------------------
module tb_scoreboard_controller;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        clear_score = 1'b0;
   logic        point_eaten = 1'b0;
   logic        pellet_eaten = 1'b0;
   logic        ghost_eaten = 1'b0;
   logic [9:0]  DrawX = 10'd0;
   logic [9:0]  DrawY = 10'd0;
   logic [23:0] score_bcd;
   logic        is_scoreboard;
   logic [3:0]  scoreboard_sprite;
   logic        is_scoreboard_1up;
   logic [1:0]  scoreboard_1up_sprite;
   logic        extra_life;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef SCORE_EXTRA_LIFE_EN
   localparam logic LIFE_EXP = 1'b1;
`else
   localparam logic LIFE_EXP = 1'b0;
`endif

   scoreboard_controller dut (
      .Clk                   (Clk),
      .Reset_n               (Reset_n),
      .frame_tick            (frame_tick),
      .clear_score           (clear_score),
      .point_eaten           (point_eaten),
      .pellet_eaten          (pellet_eaten),
      .ghost_eaten           (ghost_eaten),
      .DrawX                 (DrawX),
      .DrawY                 (DrawY),
      .score_bcd             (score_bcd),
      .is_scoreboard         (is_scoreboard),
      .scoreboard_sprite     (scoreboard_sprite),
      .is_scoreboard_1up     (is_scoreboard_1up),
      .scoreboard_1up_sprite (scoreboard_1up_sprite),
      .extra_life            (extra_life)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // One clock cycle with the given pulses; outputs settle 1 ns after the edge.
   task automatic step(input logic p, input logic pe, input logic g,
                       input logic ft, input logic clr);
      @(negedge Clk);
      point_eaten  = p;
      pellet_eaten = pe;
      ghost_eaten  = g;
      frame_tick   = ft;
      clear_score  = clr;
      @(posedge Clk);
      #1;
      point_eaten  = 1'b0;
      pellet_eaten = 1'b0;
      ghost_eaten  = 1'b0;
      frame_tick   = 1'b0;
      clear_score  = 1'b0;
   endtask

   task automatic pix(input int x, input int y);
      DrawX = 10'(x);
      DrawY = 10'(y);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      check("reset_score", 32'(score_bcd), 32'h0);
      check("reset_life", 32'(extra_life), 32'h0);
      pix(110, 5);
      check("reset_1up_visible", 32'(is_scoreboard_1up), 32'h1);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Zero score shows "00": digit 0 visible, digit 5 suppressed
      pix(132, 20);
      check("zero_d0_vis", 32'(is_scoreboard), 32'h1);
      check("zero_d0_sprite", 32'(scoreboard_sprite), 32'h0);
      pix(72, 20);
      check("zero_d5_hidden", 32'(is_scoreboard), 32'h0);
      check("zero_d5_sprite", 32'(scoreboard_sprite), 32'h0);

      // 1UP cell codes
      pix(125, 5);
      check("1up_U", 32'(scoreboard_1up_sprite), 32'h1);
      pix(140, 5);
      check("1up_P", 32'(scoreboard_1up_sprite), 32'h2);
      pix(144, 5);
      check("1up_right_edge", 32'(is_scoreboard_1up), 32'h0);

      // Blink after 16 frame ticks
      pix(110, 5);
      repeat (15) step(0, 0, 0, 1, 0);
      check("1up_after15", 32'(is_scoreboard_1up), 32'h1);
      step(0, 0, 0, 1, 0);
      check("1up_after16", 32'(is_scoreboard_1up), 32'h0);
      check("1up_blank_sprite", 32'(scoreboard_1up_sprite), 32'h0);

      // All three events at once: 10 + 50 + 200; chain index becomes 1
      step(1, 1, 1, 0, 0);
      check("sum_three", 32'(score_bcd), 32'h000260);
      step(0, 0, 1, 0, 0);
      check("chain_k1", 32'(score_bcd), 32'h000660);

      // Display shadow only follows the live score on frame_tick
      pix(120, 20);
      check("shadow_hold_d1", 32'(scoreboard_sprite), 32'h0);
      pix(108, 20);
      check("shadow_hold_d2", 32'(is_scoreboard), 32'h0);
      step(0, 0, 0, 1, 0);
      check("shadow_upd_d2_vis", 32'(is_scoreboard), 32'h1);
      check("shadow_upd_d2", 32'(scoreboard_sprite), 32'h6);
      pix(120, 20);
      check("shadow_upd_d1", 32'(scoreboard_sprite), 32'h6);
      pix(96, 20);
      check("shadow_d3_lead0", 32'(is_scoreboard), 32'h0);
      pix(120, 40);
      check("outside_rows", 32'(is_scoreboard), 32'h0);
      check("outside_sprite", 32'(scoreboard_sprite), 32'h0);

      // Clear beats a same-cycle event and clears the shadow
      step(1, 0, 0, 0, 1);
      check("clear_score", 32'(score_bcd), 32'h0);
      pix(108, 20);
      check("clear_shadow", 32'(is_scoreboard), 32'h0);

      // Ghost chain: 200+400+800+1600, then saturated 1600
      repeat (4) step(0, 0, 1, 0, 0);
      check("chain4", 32'(score_bcd), 32'h003000);
      step(0, 0, 1, 0, 0);
      check("chain5", 32'(score_bcd), 32'h004600);
      step(0, 1, 1, 0, 0);
      check("pellet_ghost", 32'(score_bcd), 32'h004850);
      step(0, 0, 1, 0, 0);
      check("after_pellet_k1", 32'(score_bcd), 32'h005250);

      // Extra life at 10000: 3000 + 6400 + 550 + 40 = 9990
      step(0, 0, 0, 0, 1);
      repeat (8)  step(0, 0, 1, 0, 0);
      repeat (11) step(0, 1, 0, 0, 0);
      repeat (4)  step(1, 0, 0, 0, 0);
      check("score_9990", 32'(score_bcd), 32'h009990);
      check("life_before", 32'(extra_life), 32'h0);
      step(1, 0, 0, 0, 0);
      check("score_10000", 32'(score_bcd), 32'h010000);
      check("life_pulse", 32'(extra_life), 32'(LIFE_EXP));
      step(0, 0, 0, 0, 0);
      check("life_one_cycle", 32'(extra_life), 32'h0);
      step(1, 0, 0, 0, 0);
      check("life_no_repeat", 32'(extra_life), 32'h0);

      // Saturation: 3000 + 623*1600 + 19*10 = 999990
      step(0, 0, 0, 0, 1);
      repeat (627) step(0, 0, 1, 0, 0);
      repeat (19)  step(1, 0, 0, 0, 0);
      check("score_999990", 32'(score_bcd), 32'h999990);
      step(1, 1, 0, 0, 0);
      check("saturate", 32'(score_bcd), 32'h999999);
      step(0, 0, 1, 0, 0);
      check("saturate_hold", 32'(score_bcd), 32'h999999);

      // Asynchronous reset mid-run, then normal operation resumes
      #2;
      Reset_n = 1'b0;
      #1;
      check("async_reset", 32'(score_bcd), 32'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
      step(1, 0, 0, 0, 0);
      check("post_reset_point", 32'(score_bcd), 32'h000010);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule
